// File: rtl/dfr_readout.sv
// DFR readout layer: per-node weighted MAC over VIRTUAL_NODES samples,
// with the frame sum presented on a valid/ready output port.
module dfr_readout #(
  parameter int unsigned VIRTUAL_NODES = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACC_WIDTH     = 72,
  localparam int unsigned IW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  w_wr_en,
  input  logic [IW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [IW-1:0]         node_idx
);

  localparam int unsigned PW = 2*DATA_WIDTH + 1;

  typedef enum logic {ACCUM, OUTPUT} state_e;

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  out_q, out_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] w_q [VIRTUAL_NODES];

  logic [DATA_WIDTH-1:0] w_cur;
  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  accept, last;

  // Unsigned sample times signed weight: zero-extend the sample, sign-extend
  // the weight, and keep the low PW bits of the unsigned product.
  assign w_cur  = w_q[idx_q];
  assign a_ext  = {{(DATA_WIDTH+1){1'b0}}, in_data};
  assign b_ext  = {{(DATA_WIDTH+1){w_cur[DATA_WIDTH-1]}}, w_cur};
  assign prod   = a_ext * b_ext;
  assign sum    = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign accept = in_valid && (state_q == ACCUM);
  assign last   = (idx_q == IW'(VIRTUAL_NODES-1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_d   = sum;
              acc_d   = '0;
              idx_d   = '0;
              state_d = OUTPUT;
            end else begin
              acc_d = sum;
              idx_d = idx_q + IW'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < VIRTUAL_NODES; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      if (w_wr_en && (32'(w_addr) < VIRTUAL_NODES)) w_q[w_addr] <= w_data;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign out_data  = out_q;
  assign node_idx  = idx_q;

endmodule

// File: tb/tb_dfr_readout.sv
// Bench for dfr_readout: table-driven uniform frames, hand-written corner
// sequences, and randomized frames against a frame-level sum model.
module tb_dfr_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        w_wr_en = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_data;
  logic [3:0]  node_idx;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [31:0] mw   [10];
  logic [31:0] samp [10];

  typedef struct {
    string              name;
    logic [31:0]        w;
    logic [31:0]        s;
    logic signed [71:0] exp;
  } vec_t;
  vec_t vt [6];

  dfr_readout #(.VIRTUAL_NODES(10), .DATA_WIDTH(32), .ACC_WIDTH(72)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .node_idx(node_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic signed [71:0] model_sum();
    logic signed [71:0] s;
    s = '0;
    for (int i = 0; i < 10; i++)
      s += $signed({40'b0, samp[i]}) * $signed({{40{mw[i][31]}}, mw[i]});
    return s;
  endfunction

  task automatic write_w(input logic [3:0] a, input logic [31:0] d);
    w_wr_en = 1'b1; w_addr = a; w_data = d;
    step();
    w_wr_en = 1'b0;
    if (a < 4'd10) mw[a] = d;
  endtask

  task automatic fill_w(input logic [31:0] d);
    for (int i = 0; i < 10; i++) write_w(4'(i), d);
  endtask

  task automatic send_sample(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) chk("in_ready_timeout", 72'(in_ready), 72'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(2);
        in_data = $urandom;
        repeat (g) step();
      end
      send_sample(samp[i]);
    end
  endtask

  task automatic get_result(input string name, input logic [71:0] exp, input int delay);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk({name, "_valid"}, 72'(out_valid), 72'd1);
    chk({name, "_data"}, out_data, exp);
    repeat (delay) begin
      step();
      chk({name, "_hold"}, {70'd0, out_valid, in_ready}, {70'd0, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{"neg2", 32'hFFFFFFFE, 32'h00001000, -72'sd81920};
    vt[1] = '{"neg2_again", 32'hFFFFFFFE, 32'h00001000, -72'sd81920};
    vt[2] = '{"maxmag", 32'h7FFFFFFF, 32'hFFFFFFFF, 72'sh4_FFFFFFF1_0000000A};
    vt[3] = '{"ones_by_two", 32'h00000001, 32'h00000002, 72'sd20};
    vt[4] = '{"zero_w", 32'h00000000, 32'h12345678, 72'sd0};
    vt[5] = '{"neg1_max", 32'hFFFFFFFF, 32'hFFFFFFFF, -72'sd42949672950};
    for (int i = 0; i < 10; i++) mw[i] = '0;

    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_out_data", out_data, 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_node_idx", 72'(node_idx), 72'd0);

    // weights 1, samples 1..10, out_valid exactly one cycle after last accept
    fill_w(32'd1);
    for (int i = 0; i < 10; i++) samp[i] = 32'(i + 1);
    for (int i = 0; i < 9; i++) send_sample(samp[i]);
    chk("idx_before_last", 72'(node_idx), 72'd9);
    send_sample(samp[9]);
    chk("lat_out_valid", 72'(out_valid), 72'd1);
    chk("lat_out_data", out_data, 72'd55);
    chk("lat_node_idx", 72'(node_idx), 72'd0);

    // backpressure with in_valid held high
    in_valid = 1'b1; in_data = 32'h7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 72'(out_valid), 72'd1);
      chk("bp_data", out_data, 72'd55);
      chk("bp_in_ready", 72'(in_ready), 72'd0);
      chk("bp_idx", 72'(node_idx), 72'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_release_in_ready", 72'(in_ready), 72'd1);
    chk("bp_release_valid", 72'(out_valid), 72'd0);
    chk("bp_release_idx", 72'(node_idx), 72'd0);

    for (int v = 0; v < 6; v++) begin
      fill_w(vt[v].w);
      for (int i = 0; i < 10; i++) samp[i] = vt[v].s;
      send_frame(1'b0);
      get_result(vt[v].name, vt[v].exp, 0);
    end

    // clear after 4 samples, sample in the clear cycle discarded
    fill_w(32'd1);
    for (int i = 0; i < 4; i++) send_sample(32'd2);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd9;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_idx", 72'(node_idx), 72'd0);
    for (int i = 0; i < 10; i++) samp[i] = 32'd2;
    send_frame(1'b0);
    get_result("clr_frame", 72'd20, 0);

    // clear drops a pending result
    send_frame(1'b0);
    while (!out_valid) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_drop_valid", 72'(out_valid), 72'd0);
    chk("clr_drop_ready", 72'(in_ready), 72'd1);

    // out-of-range weight address ignored
    write_w(4'd12, 32'h00000100);
    for (int i = 0; i < 10; i++) samp[i] = 32'd1;
    send_frame(1'b0);
    get_result("waddr12", 72'd10, 0);

    // same-cycle weight write uses old value for that sample
    fill_w(32'd0);
    write_w(4'd0, 32'd3);
    in_valid = 1'b1; in_data = 32'd1;
    w_wr_en = 1'b1; w_addr = 4'd0; w_data = 32'd5;
    step();
    in_valid = 1'b0; w_wr_en = 1'b0;
    for (int i = 1; i < 10; i++) send_sample(32'd0);
    get_result("wr_same_cycle", 72'd3, 0);
    samp[0] = 32'd1;
    for (int i = 1; i < 10; i++) samp[i] = 32'd0;
    send_frame(1'b0);
    get_result("wr_next_frame", 72'd5, 0);

    // reset mid-frame zeroes outputs and weights
    fill_w(32'd7);
    for (int i = 0; i < 4; i++) send_sample(32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) mw[i] = '0;
    chk("mrst_out_data", out_data, 72'd0);
    chk("mrst_idx", 72'(node_idx), 72'd0);
    chk("mrst_valid", 72'(out_valid), 72'd0);
    for (int i = 0; i < 10; i++) samp[i] = 32'd1000;
    send_frame(1'b0);
    get_result("mrst_weights_zero", 72'd0, 0);

    // randomized frames against the model
    for (int f = 0; f < 25; f++) begin
      int nw;
      nw = $urandom_range(12);
      for (int k = 0; k < nw; k++)
        write_w(4'($urandom_range(15)), (f % 3 == 0) ? 32'($urandom_range(200)) - 32'd100 : $urandom);
      for (int i = 0; i < 10; i++)
        samp[i] = (f % 2 == 0) ? $urandom : 32'($urandom_range(1000));
      send_frame(1'b1);
      get_result("rand_frame", model_sum(), $urandom_range(3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dfr_readout.md
Name: dfr_readout

Overview:
Output (readout) layer of the DFR datapath, consuming the reservoir's node output stream.
- Accepts one reservoir node sample per valid/ready handshake.
- Multiplies each sample by a per-node trained weight and accumulates over VIRTUAL_NODES samples.
- Presents the frame's weighted sum on a valid/ready output port.
- Weights are loaded through a simple write port from the host/config side.

Parameters:
VIRTUAL_NODES, 10, samples per frame; also the number of weight registers.
DATA_WIDTH, 32, width of the node sample and of each weight.
ACC_WIDTH, 72, accumulator and output width; must be >= 2*DATA_WIDTH+1+clog2(VIRTUAL_NODES).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-low (0 = reset).
clear  input  1  synchronous frame abort; active-high.
in_valid  input  1  node sample valid.
in_ready  output  1  block can accept a sample.
in_data  input  DATA_WIDTH  node sample, unsigned.
w_wr_en  input  1  weight write strobe.
w_addr  input  clog2(VIRTUAL_NODES)  weight index.
w_data  input  DATA_WIDTH  weight, signed two's complement.
out_valid  output  1  frame result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  ACC_WIDTH  weighted sum, signed two's complement.
node_idx  output  clog2(VIRTUAL_NODES)  index of the next expected sample.

Behaviour:
Reset (rst==0 at a clock edge):
- state=ACCUM, acc=0, node_idx=0, out_valid=0, out_data=0.
- in_ready=1 from the first cycle after reset.
- All weights=0.
- Reset overrides clear, writes and handshakes.

FSM has two states: ACCUM and OUTPUT.

ACCUM:
- in_ready=1, out_valid=0.
- On in_valid&&in_ready: acc <= acc + sext(prod), where prod = $signed({1'b0,in_data}) * $signed(w[node_idx]).
- prod is 2*DATA_WIDTH+1 bits; acc wraps modulo 2^ACC_WIDTH.
- On an accepted sample with node_idx<VIRTUAL_NODES-1: node_idx increments.
- On an accepted sample with node_idx==VIRTUAL_NODES-1:
  - out_data <= final sum, which includes this product.
  - acc <= 0, node_idx <= 0, state <= OUTPUT.
  - out_valid=1 on the next cycle, so latency from the last accepted sample to out_valid is 1 cycle.
- in_valid with in_ready=0 is ignored; no sample is consumed.

OUTPUT:
- in_ready=0, out_valid=1.
- out_data holds stable until the handshake completes.
- On out_ready: state <= ACCUM next cycle, so out_valid and in_ready flip on the following cycle.
- No sample is accepted in the same cycle as the output handshake; the minimum frame period is VIRTUAL_NODES+1 cycles.

Weights:
- w_wr_en writes w[w_addr] <= w_data in any state.
- w_addr >= VIRTUAL_NODES: the write is ignored.
- A write to the weight being used in the same cycle: the MAC uses the old value, and the new value is visible next cycle.

clear (rst high):
- acc <= 0, node_idx <= 0, state <= ACCUM, out_valid <= 0.
- Any pending result is dropped.
- A sample presented in the same cycle is discarded.
- Weights are unchanged.

Multiplier/adder is single-cycle combinational into the acc register; no pipelining.

Test Plan:
- Weights all 1, samples 1..10 (VIRTUAL_NODES=10): out_valid one cycle after the 10th accept, out_data=55; node_idx returns to 0.
- Weights all 0xFFFFFFFE (-2), samples all 0x00001000: out_data = -81920 (sign-extended to 72 bits); second frame with the same stimulus gives the same value (acc cleared).
- Backpressure: out_ready low for 5 cycles after out_valid, in_valid held high with 0x7:
  - out_data and out_valid stay stable; in_ready=0; no sample consumed.
  - After out_ready=1, in_ready=1 one cycle later.
- Max magnitude: weights 0x7FFFFFFF, samples 0xFFFFFFFF ×10 → out_data = 10*(2^32-1)*(2^31-1), exact with no wrap.
- clear after 4 samples, then 10 samples with weights=1 and value 2 → out_data=20.
- w_addr=12 write ignored.
- rst low mid-frame → outputs zero, weights zero.
- Weight write to index 0 in the same cycle as sample 0 (old w=3, new w=5, sample=1) → contributes 3.
- Next frame, sample 0 =1 → contributes 5.
